axi_lite_obi_bridge: RTL

AXI4-Lite slave to OBI master bridge, the parametrised successor of the single-word serial-link bridge in core-v-mini-mcu. It sits between an external AXI4-Lite master (serial link / debug host) and an OBI crossbar master port. It decouples the AW and W channels, arbitrates fairly between reads and writes, maps `wstrb` to OBI `be`, and returns OKAY/SLVERR/DECERR responses. It has one OBI transaction in flight at a time.

---
 rtl/axi_lite_obi_bridge_if.sv | 80 ++++++++
 rtl/axi_lite_obi_bridge.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/axi_lite_obi_bridge_if.sv
// AXI4-Lite and OBI bus bundles used by axi_lite_obi_bridge.
interface axi_lite_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [AddrWidth-1:0] s00_axi_awaddr;
  logic [2:0]           s00_axi_awprot;
  logic                 s00_axi_awvalid;
  logic                 s00_axi_awready;
  logic [DataWidth-1:0] s00_axi_wdata;
  logic [StrbWidth-1:0] s00_axi_wstrb;
  logic                 s00_axi_wvalid;
  logic                 s00_axi_wready;
  logic [1:0]           s00_axi_bresp;
  logic                 s00_axi_bvalid;
  logic                 s00_axi_bready;
  logic [AddrWidth-1:0] s00_axi_araddr;
  logic [2:0]           s00_axi_arprot;
  logic                 s00_axi_arvalid;
  logic                 s00_axi_arready;
  logic [DataWidth-1:0] s00_axi_rdata;
  logic [1:0]           s00_axi_rresp;
  logic                 s00_axi_rvalid;
  logic                 s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );
endinterface

interface obi_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                 obi_req_o;
  logic                 obi_gnt_i;
  logic [AddrWidth-1:0] obi_addr_o;
  logic                 obi_we_o;
  logic [StrbWidth-1:0] obi_be_o;
  logic [DataWidth-1:0] obi_wdata_o;
  logic                 obi_rvalid_i;
  logic [DataWidth-1:0] obi_rdata_i;
  logic                 obi_err_i;

  modport master (
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );

  modport slave (
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );
endinterface

// File: rtl/axi_lite_obi_bridge.sv
// AXI4-Lite slave to OBI master bridge, one OBI transaction in flight,
// fair read/write arbitration and address-window decode.
module axi_lite_obi_bridge #(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] AddrBase  = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] AddrSize  = 32'h0010_0000
) (
  input logic         s00_axi_aclk,
  input logic         s00_axi_aresetn,
  axi_lite_if.slave   axi,
  obi_if.master       obi
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [AddrWidth:0] Lo = {1'b0, AddrBase};
  localparam logic [AddrWidth:0] Hi = Lo + {1'b0, AddrSize};

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic                 aw_vld, w_vld, ar_vld;
  logic [AddrWidth-1:0] aw_addr, ar_addr;
  logic [DataWidth-1:0] w_data;
  logic [StrbWidth-1:0] w_strb;
  logic                 sel_q, sel_d;
  logic                 lww_q, lww_d;
  logic [1:0]           resp_q, resp_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic                 wr_pend, rd_pend, pick_wr, in_range, hs;
  logic [AddrWidth-1:0] pick_addr;
  logic                 unused_prot;

  assign unused_prot = ^{axi.s00_axi_awprot, axi.s00_axi_arprot};

  assign wr_pend   = aw_vld & w_vld;
  assign rd_pend   = ar_vld;
  // On a tie the kind not served last wins
  assign pick_wr   = wr_pend & (~rd_pend | ~lww_q);
  assign pick_addr = pick_wr ? aw_addr : ar_addr;
  assign in_range  = ({1'b0, pick_addr} >= Lo) && ({1'b0, pick_addr} < Hi);
  assign hs        = (state_q == RESP) &&
                     (sel_q ? axi.s00_axi_bready : axi.s00_axi_rready);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      lww_q   <= 1'b0;
      resp_q  <= 2'b00;
      rdata_q <= '0;
      aw_vld  <= 1'b0;
      w_vld   <= 1'b0;
      ar_vld  <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lww_q   <= lww_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      if (axi.s00_axi_awvalid && !aw_vld) begin
        aw_vld  <= 1'b1;
        aw_addr <= axi.s00_axi_awaddr;
      end else if (hs && sel_q) begin
        aw_vld  <= 1'b0;
      end
      if (axi.s00_axi_wvalid && !w_vld) begin
        w_vld  <= 1'b1;
        w_data <= axi.s00_axi_wdata;
        w_strb <= axi.s00_axi_wstrb;
      end else if (hs && sel_q) begin
        w_vld  <= 1'b0;
      end
      if (axi.s00_axi_arvalid && !ar_vld) begin
        ar_vld  <= 1'b1;
        ar_addr <= axi.s00_axi_araddr;
      end else if (hs && !sel_q) begin
        ar_vld  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lww_d   = lww_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (wr_pend || rd_pend) begin
          sel_d   = pick_wr;
          resp_d  = 2'b00;
          rdata_d = '0;
          if (!in_range) begin
            resp_d  = 2'b11;
            state_d = RESP;
          end else if (pick_wr && (w_strb == '0)) begin
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (obi.obi_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (obi.obi_rvalid_i) begin
          resp_d = obi.obi_err_i ? 2'b10 : 2'b00;
          if (!sel_q) rdata_d = obi.obi_rdata_i;
          state_d = RESP;
        end
      end
      RESP: begin
        if (hs) begin
          lww_d   = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi.s00_axi_awready = ~aw_vld;
  assign axi.s00_axi_wready  = ~w_vld;
  assign axi.s00_axi_arready = ~ar_vld;
  assign axi.s00_axi_bvalid  = (state_q == RESP) & sel_q;
  assign axi.s00_axi_rvalid  = (state_q == RESP) & ~sel_q;
  assign axi.s00_axi_bresp   = resp_q;
  assign axi.s00_axi_rresp   = resp_q;
  assign axi.s00_axi_rdata   = rdata_q;

  assign obi.obi_req_o   = (state_q == REQ);
  assign obi.obi_we_o    = obi.obi_req_o & sel_q;
  assign obi.obi_addr_o  = obi.obi_req_o ? (sel_q ? aw_addr : ar_addr) : '0;
  assign obi.obi_be_o    = obi.obi_req_o ? (sel_q ? w_strb : '1) : '0;
  assign obi.obi_wdata_o = (obi.obi_req_o && sel_q) ? w_data : '0;
endmodule
